// File: rtl/hv_stream_pkg.sv
// Shared types and width constants for the hypervector stream path.
// The packer's word width doubles as the downstream fifo's DataWidth.
package hv_stream_pkg;

  // Packer control state: collecting beats, or offering a full word to the fifo.
  typedef enum logic {
    PackFill = 1'b0,
    PackPush = 1'b1
  } pack_state_e;

  // Default narrow beat width and beats per packed word.
  localparam int unsigned BeatWidth = 32;
  localparam int unsigned PackBeats = 8;

  // Packed word width; the fifo in front of the encoder uses this as DataWidth.
  localparam int unsigned DataWidth = BeatWidth * PackBeats;

endpackage

// File: rtl/hv_word_packer.sv
// hv_word_packer: packs NumBeats narrow beats (beat 0 at the LSB) into one
// wide word and pushes it into the downstream fifo via push/full.
// Holds a single word; back-pressures the source while that word waits.
//
// Handshake semantics: an input beat transfers in a cycle where
// in_valid_i & in_ready_o are both 1; in_ready_o depends only on the state.
// A word transfers to the fifo in a cycle where fifo_push_o is 1, which is
// never the case while fifo_full_i is 1.
//
// Optional feature macro HV_PACKER_LAST_FLUSH_EN: when defined, a beat with
// in_last_i=1 closes the word early (upper beats stay zero). When undefined,
// in_last_i is ignored and words are emitted only when full.
module hv_word_packer
  import hv_stream_pkg::*;
#(
  parameter int unsigned InWidth    = BeatWidth,
  parameter int unsigned NumBeats   = PackBeats,
  localparam int unsigned OutWidth  = InWidth * NumBeats,
  localparam int unsigned CntWidth  = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [InWidth-1:0]  in_data_i,
  input  logic                in_valid_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [OutWidth-1:0] fifo_data_o,
  output logic                fifo_push_o,
  input  logic                fifo_full_i,
  output logic [CntWidth:0]   beat_cnt_o,
  output logic                busy_o
);

  localparam logic [CntWidth:0] FullCnt = (CntWidth + 1)'(NumBeats);

  pack_state_e         state_q;
  logic [OutWidth-1:0] buf_q;
  logic [CntWidth:0]   cnt_q;
  logic [CntWidth:0]   cnt_d;
  logic                in_hs;
  logic                word_done;
  logic                push;

  // Ready is a pure function of state, so fifo_full_i never reaches the source.
  assign in_ready_o = (state_q == PackFill);
  assign in_hs      = in_valid_i & in_ready_o;
  assign cnt_d      = cnt_q + 1'b1;

`ifdef HV_PACKER_LAST_FLUSH_EN
  // A last beat closes the word regardless of how many beats it holds.
  assign word_done = (cnt_d == FullCnt) | in_last_i;
`else
  assign word_done = (cnt_d == FullCnt);
  logic unused_last;
  assign unused_last = in_last_i;
`endif

  // A clear in the push cycle suppresses the push so the dropped word never lands.
  assign push = (state_q == PackPush) & ~fifo_full_i & ~clr_i;

  // Fill/push state machine with the inline beat counter and word buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PackFill;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else if (clr_i) begin
      state_q <= PackFill;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        PackFill: begin
          if (in_hs) begin
            for (int b = 0; b < NumBeats; b++) begin
              if (cnt_q == (CntWidth + 1)'(b)) begin
                buf_q[b*InWidth +: InWidth] <= in_data_i;
              end
            end
            cnt_q <= cnt_d;
            if (word_done) begin
              state_q <= PackPush;
            end
          end
        end
        PackPush: begin
          // Zeroing the buffer here gives the next (possibly short) word zero padding.
          if (push) begin
            state_q <= PackFill;
            cnt_q   <= '0;
            buf_q   <= '0;
          end
        end
      endcase
    end
  end

  assign fifo_push_o = push;
  assign fifo_data_o = buf_q;
  assign beat_cnt_o  = cnt_q;
  assign busy_o      = (cnt_q != '0) | (state_q == PackPush);

endmodule

// File: doc/hv_word_packer.md
# hv_word_packer

Upstream feeder for the common `fifo`. Accepts a narrow valid/ready stream (e.g. hypervector segments from a memory streamer), packs `NumBeats` consecutive beats into one wide word, and pushes that word into the FIFO through its `push_i`/`full_o` interface. It gives the encoder datapath full-width hypervectors from a narrow bus. Holds one word at a time and back-pressures the source while the FIFO is full.

## Interface
- `InWidth`, 32, width of one input beat.
- `NumBeats`, 8, beats per packed word; must be ≥1.
- `OutWidth`, `InWidth*NumBeats`, packed word width; derived, never overridden.
- `CntWidth`, `(NumBeats>1) ? $clog2(NumBeats) : 1`, derived.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clr_i`  in  1  synchronous clear; drops any partial word.
- `in_data_i`  in  InWidth  beat data.
- `in_valid_i`  in  1  beat valid.
- `in_last_i`  in  1  final beat of a vector; used only with the macro enabled.
- `in_ready_o`  out  1  packer accepts a beat.
- `fifo_data_o`  out  OutWidth  packed word; drives FIFO `data_i`.
- `fifo_push_o`  out  1  push strobe; drives FIFO `push_i`.
- `fifo_full_i`  in  1  from FIFO `full_o`.
- `beat_cnt_o`  out  CntWidth+1  beats stored in the current word (0..NumBeats).
- `busy_o`  out  1  partial or complete word held.

## Operation
- Two states: FILL and PUSH. Registers: `buf_q` (OutWidth), `cnt_q` (CntWidth+1), `state_q`.
- Reset and `clr_i` set `state_q`=FILL, `cnt_q`=0, `buf_q`=0. `clr_i` takes priority over every other event.
- FILL:
  - `in_ready_o`=1.
  - A handshake (`in_valid_i & in_ready_o`) writes `in_data_i` to `buf_q[cnt_q*InWidth +: InWidth]`, so beat 0 lands at the LSB. `cnt_q` increments.
  - The handshake that brings `cnt_q` to NumBeats moves the state to PUSH.
- PUSH:
  - `in_ready_o`=0.
  - `fifo_push_o = ~fifo_full_i`.
  - `fifo_data_o` = `buf_q`, held stable while stalled.
  - In a cycle with `fifo_push_o`=1, the next state is FILL, `cnt_q`=0 and `buf_q`=0. Zeroing `buf_q` guarantees padding for the next word.
- `fifo_push_o` is never asserted while `fifo_full_i`=1, so the FIFO's full-write check never fires.
- `fifo_data_o` = `buf_q` in all states. Only `fifo_push_o` qualifies it.
- `beat_cnt_o` = `cnt_q`.
- `busy_o` = (`cnt_q`≠0) | (state==PUSH).
- `in_valid_i` asserted in PUSH is ignored. The source must hold the beat, per valid/ready rules.

## Timing
- Reset values: `in_ready_o`=1, `fifo_push_o`=0, `fifo_data_o`=0, `beat_cnt_o`=0, `busy_o`=0.
- Latency: final beat accepted in cycle N → earliest `fifo_push_o` in cycle N+1.
- Throughput: one word per NumBeats+1 cycles with no back-pressure. The bubble cycle is PUSH.
- `fifo_full_i` stall: remains in PUSH indefinitely, with no combinational path from `in_valid_i` to `fifo_push_o`.
- `in_ready_o` depends only on state, with no combinational path from `fifo_full_i`.
- Reset asserted mid-word or in PUSH: all outputs take reset values immediately, asynchronously, and the word is lost.
- `clr_i` in PUSH with `fifo_full_i`=0: no push is issued (`fifo_push_o` is forced to 0 that cycle) and the word is dropped.
- NumBeats=1: every accepted beat produces a push in the following cycle.

## Configuration
- Macro: `HV_PACKER_LAST_FLUSH_EN`.
- Defined: a FILL handshake with `in_last_i`=1 stores the beat and moves to PUSH regardless of count. The unfilled upper beats are zero and `beat_cnt_o` reports the beats actually stored. `in_last_i` on the NumBeats-th beat behaves the same as a normal completion.
- Undefined: `in_last_i` is ignored (port retained, unused), and words are emitted only when full.

## Structure
- Package `hv_stream_pkg` holds:
  - `typedef enum logic {PackFill, PackPush} pack_state_e`;
  - the shared beat and word width constants reused by the downstream `fifo` instance (`DataWidth = OutWidth`).
- No sub-module. The counter and buffer are inline. Integration instantiates `hv_word_packer` directly in front of `fifo`.

## Test plan
All scenarios use `InWidth`=8 and `NumBeats`=4.
- Beats 0x11, 0x22, 0x33, 0x44 back-to-back → next cycle `fifo_push_o`=1, `fifo_data_o`=0x44332211, `in_ready_o`=0; the following cycle `in_ready_o`=1 and `beat_cnt_o`=0.
- Same word with `fifo_full_i`=1 for 3 cycles → `fifo_push_o`=0 and data held at 0x44332211 throughout; push occurs in the cycle `fifo_full_i` drops.
- Macro on: beats 0xAA, then 0xBB with `in_last_i` → push of 0x0000BBAA with `beat_cnt_o`=2. Macro off: same stimulus → no push, `beat_cnt_o`=2, `in_ready_o`=1.
- `clr_i` after 2 beats, then 0x01..0x04 → single push of 0x04030201, with no residue from the cleared beats.
- `rst_ni` low while in PUSH → `fifo_push_o`, `fifo_data_o`, `busy_o` all 0 and `in_ready_o`=1 immediately.
- End-to-end with `fifo` (FifoDepth=2) and a sink stalled for 20 beats → FIFO fills, the packer parks in PUSH, no beats are lost, and 5 words drain in order.
